// File: rtl/main_mem_ctrl_pkg.sv
// Shared types and defaults for the main-memory responder behind the
// core's icache/dcache memory-controller ports.
package main_mem_ctrl_pkg;

    localparam int BLOCK_ADDR_W = 29;
    localparam int BLOCK_DATA_W = 64;
    localparam int MEM_N_BLOCKS = 1024;
    localparam int MEM_LATENCY  = 4;

    typedef logic [BLOCK_ADDR_W-1:0] main_mem_block_addr_t;
    typedef logic [BLOCK_DATA_W-1:0] block_data_t;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_t;

    localparam logic REQ_ID_ICACHE = 1'b0;
    localparam logic REQ_ID_DCACHE = 1'b1;

endpackage

// File: rtl/main_mem_ctrl_rr_arbiter.sv
// Two-way round-robin arbiter between icache and dcache requesters.
// Readys are combinational; last_grant only moves on an actual handshake.
module main_mem_ctrl_rr_arbiter (
    input  logic clk,
    input  logic rst_aL,
    input  logic enable,
    input  logic icache_valid,
    input  logic dcache_valid,
    output logic icache_ready,
    output logic dcache_ready
);
    import main_mem_ctrl_pkg::*;

    logic last_grant_q, last_grant_d;
    logic grant_dc, grant_ic;

    always_comb begin
        // On a tie the requester that did not win last time gets the slot.
        grant_dc     = dcache_valid && (!icache_valid || (last_grant_q == REQ_ID_ICACHE));
        grant_ic     = icache_valid && !grant_dc;
        icache_ready = enable && grant_ic;
        dcache_ready = enable && grant_dc;
        last_grant_d = last_grant_q;
        if (dcache_ready) begin
            last_grant_d = REQ_ID_DCACHE;
        end else if (icache_ready) begin
            last_grant_d = REQ_ID_ICACHE;
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            last_grant_q <= REQ_ID_ICACHE;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/main_mem_ctrl.sv
// Block-granular backing store serving one icache/dcache request at a time,
// each answered by a single-cycle registered response LATENCY cycles later.
//
//   state   | meaning
//   IDLE    | accepting requests (unless init preload is active)
//   BUSY    | latency down-counter running for the captured request
//   RESP    | one-cycle response pulse on the captured requester's port
module main_mem_ctrl #(
    parameter int BLOCK_ADDR_WIDTH = main_mem_ctrl_pkg::BLOCK_ADDR_W,
    parameter int BLOCK_DATA_WIDTH = main_mem_ctrl_pkg::BLOCK_DATA_W,
    parameter int MEM_N_BLOCKS     = main_mem_ctrl_pkg::MEM_N_BLOCKS,
    parameter int LATENCY          = main_mem_ctrl_pkg::MEM_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst_aL,
    input  logic                        init,
    input  logic                        init_wr_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0] init_wr_block_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] init_wr_block_data,
    input  logic                        icache_req_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0] icache_req_block_addr,
    output logic                        icache_req_ready,
    output logic                        icache_resp_valid,
    output logic [BLOCK_DATA_WIDTH-1:0] icache_resp_block_data,
    input  logic                        dcache_req_valid,
    input  logic                        dcache_req_type,
    input  logic [BLOCK_ADDR_WIDTH-1:0] dcache_req_block_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] dcache_req_block_data,
    output logic                        dcache_req_ready,
    output logic                        dcache_resp_valid,
    output logic [BLOCK_DATA_WIDTH-1:0] dcache_resp_block_data
);
    import main_mem_ctrl_pkg::*;

    localparam int IDX_W = $clog2(MEM_N_BLOCKS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        id_q, id_d;
    logic                        type_q, type_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [BLOCK_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                        ic_rv_q, ic_rv_d, dc_rv_q, dc_rv_d;
    logic [BLOCK_DATA_WIDTH-1:0] ic_rd_q, ic_rd_d, dc_rd_q, dc_rd_d;
    logic [BLOCK_DATA_WIDTH-1:0] store [MEM_N_BLOCKS];

    logic                        arb_en, ic_fire, dc_fire, resp_go;
    logic [BLOCK_DATA_WIDTH-1:0] resp_data;
    logic                        unused_addr_hi;

    // Only the low index bits select a block; higher address bits alias.
    assign unused_addr_hi = ^{icache_req_block_addr[BLOCK_ADDR_WIDTH-1:IDX_W],
                              dcache_req_block_addr[BLOCK_ADDR_WIDTH-1:IDX_W],
                              init_wr_block_addr[BLOCK_ADDR_WIDTH-1:IDX_W]};

    assign arb_en = (state_q == ST_IDLE) && !init;

    main_mem_ctrl_rr_arbiter u_arb (
        .clk          (clk),
        .rst_aL       (rst_aL),
        .enable       (arb_en),
        .icache_valid (icache_req_valid),
        .dcache_valid (dcache_req_valid),
        .icache_ready (icache_req_ready),
        .dcache_ready (dcache_req_ready)
    );

    assign ic_fire = icache_req_valid && icache_req_ready;
    assign dc_fire = dcache_req_valid && dcache_req_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        type_d    = type_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        ic_rv_d   = 1'b0;
        dc_rv_d   = 1'b0;
        ic_rd_d   = ic_rd_q;
        dc_rd_d   = dc_rd_q;
        resp_go   = 1'b0;
        resp_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (dc_fire) begin
                    id_d    = REQ_ID_DCACHE;
                    type_d  = dcache_req_type;
                    idx_d   = dcache_req_block_addr[IDX_W-1:0];
                    wdata_d = dcache_req_block_data;
                end else if (ic_fire) begin
                    id_d    = REQ_ID_ICACHE;
                    type_d  = REQ_READ;
                    idx_d   = icache_req_block_addr[IDX_W-1:0];
                end
                if (dc_fire || ic_fire) begin
                    if (LATENCY == 1) begin
                        resp_go = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    resp_go = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Response regs load on the edge entering RESP so they are visible during RESP.
        if (resp_go) begin
            state_d   = ST_RESP;
            resp_data = (type_d == REQ_WRITE) ? wdata_d : store[idx_d];
            if (id_d == REQ_ID_DCACHE) begin
                dc_rv_d = 1'b1;
                dc_rd_d = resp_data;
            end else begin
                ic_rv_d = 1'b1;
                ic_rd_d = resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            id_q    <= REQ_ID_ICACHE;
            type_q  <= REQ_READ;
            idx_q   <= '0;
            wdata_q <= '0;
            ic_rv_q <= 1'b0;
            dc_rv_q <= 1'b0;
            ic_rd_q <= '0;
            dc_rd_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            type_q  <= type_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            ic_rv_q <= ic_rv_d;
            dc_rv_q <= dc_rv_d;
            ic_rd_q <= ic_rd_d;
            dc_rd_q <= dc_rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (init && init_wr_valid && (state_q == ST_IDLE)) begin
            store[init_wr_block_addr[IDX_W-1:0]] <= init_wr_block_data;
        end else if (resp_go && (type_d == REQ_WRITE)) begin
            store[idx_d] <= wdata_d;
        end
    end

    assign icache_resp_valid      = ic_rv_q;
    assign icache_resp_block_data = ic_rd_q;
    assign dcache_resp_valid      = dc_rv_q;
    assign dcache_resp_block_data = dc_rd_q;

endmodule

// File: doc/main_mem_ctrl.md
Name: main_mem_ctrl

Overview:
Main-memory responder for the core's ICACHE and DCACHE memory-controller request/response interfaces. It owns a block-granular backing store and arbitrates between the two cache requesters, serving one request at a time. Each request receives a single-cycle response after a fixed latency. It sits outside the core in the top-level/testbench and is the other end of the core's mem_ctrl ports.

Parameters:
BLOCK_ADDR_WIDTH, 29, width of main_mem_block_addr_t (32-bit byte address, 8-byte blocks)
BLOCK_DATA_WIDTH, 64, width of block_data_t
MEM_N_BLOCKS, 1024, backing-store depth in blocks (power of two); indexed by low log2(MEM_N_BLOCKS) bits of block address
LATENCY, 4, cycles from request handshake to resp_valid; must be >= 1

Ports:
clk  in  1  clock, all state on rising edge
rst_aL  in  1  asynchronous active-low reset
init  in  1  backdoor preload mode; blocks all requests while high
init_wr_valid  in  1  backdoor block write strobe (honoured only while init=1)
init_wr_block_addr  in  BLOCK_ADDR_WIDTH  backdoor write address
init_wr_block_data  in  BLOCK_DATA_WIDTH  backdoor write data
icache_req_valid  in  1  icache read request
icache_req_block_addr  in  BLOCK_ADDR_WIDTH  icache block address
icache_req_ready  out  1  request accepted this cycle when valid&ready
icache_resp_valid  out  1  one-cycle response pulse
icache_resp_block_data  out  BLOCK_DATA_WIDTH  read data, valid with resp_valid
dcache_req_valid  in  1  dcache request
dcache_req_type  in  1  req_type_t: 0 read, 1 write
dcache_req_block_addr  in  BLOCK_ADDR_WIDTH  dcache block address
dcache_req_block_data  in  BLOCK_DATA_WIDTH  write data
dcache_req_ready  out  1  request accepted when valid&ready
dcache_resp_valid  out  1  one-cycle response pulse (read data or write ack)
dcache_resp_block_data  out  BLOCK_DATA_WIDTH  read data; write data echoed for writes

Behaviour:
- Reset (rst_aL=0, async): FSM->IDLE, latency counter=0, last_grant=icache (so dcache wins first tie), all outputs 0. Backing store NOT reset. Reset mid-request drops the request silently; no response is produced.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if init=1, both readys=0 and no grant; an init_wr_valid writes the store the same edge. Otherwise grant = round-robin:
  - only one requester valid -> that one;
  - both valid -> the one not in last_grant.
- Readys are combinational: req_ready = (state==IDLE) & !init & grant-to-that-requester. Requesters' valid never depends on ready, so there is no loop.
- On fire (valid&ready): capture requester id, type (icache forced read), address, and write data; update last_grant. If LATENCY==1 go to RESP, else go to BUSY with counter=LATENCY-1.
- BUSY: decrement counter each cycle; when counter==1, go to RESP.
- RESP (exactly one cycle):
  - read: resp_data = store[idx];
  - write: store[idx] <= wdata, and resp_data = wdata.
  - Assert the captured requester's resp_valid and data. These are registered outputs, asserted in the cycle that is LATENCY cycles after the fire cycle.
  - Then go to IDLE. The earliest next fire is the cycle after the resp pulse.
- resp_valid for the non-served requester stays 0. resp_block_data holds its last value when resp_valid=0.
- Responses are never cancelled. Core flush/redirect does not abort an in-flight request; the requester discards it.
- Address bits above log2(MEM_N_BLOCKS) are ignored (aliasing).
- Simultaneous init rising edge while BUSY/RESP: the in-flight request completes; no new grant until init=0.

Decomposition:
- Shared package (global_defs): main_mem_block_addr_t, block_data_t, req_type_t {READ=0, WRITE=1}, MEM_N_BLOCKS, MEM_LATENCY.
- Local: FSM state enum and requester-id bit.
- Sub-module: mem_ctrl_rr_arbiter (2-way round-robin with last_grant register, ready generation).
- Storage is a plain reg array inside main_mem_ctrl.

Test Plan:
- Preload: init=1, write block 5 = 0xDEAD_BEEF_0000_0005; init=0; icache read addr 5 at cycle t -> icache_resp_valid only at t+4, data 0xDEAD_BEEF_0000_0005; icache_req_ready=0 at t+1..t+4.
- Dcache write addr 9 data 0x1234 fired at t -> dcache_resp_valid at t+4 echoing 0x1234; dcache read addr 9 fired at t+5 -> data 0x1234 at t+9.
- Both valid from reset, held continuously -> grant order dcache, icache, dcache, icache; each resp on the correct port only; no fire while BUSY/RESP.
- Reset asserted two cycles after an icache fire -> no icache_resp_valid ever; after release, a new request is served normally; store contents preserved.
- Aliasing: write addr 1024+3 = 0xAA, read addr 3 -> 0xAA. LATENCY=1 build: fire at t -> resp at t+1, next fire accepted at t+2.
